booth_seq_multiplier: RTL and testbench

Iterative radix-4 Booth multiplier with valid/ready handshakes on both sides, selectable signed/unsigned operation per transaction, and a parametrised number of Booth digits retired per clock. It is the sequential successor to the combinational Booth partial-product encoder. It trades area for latency by recoding and accumulating `DIGITS_PER_CYCLE` partial products each cycle into a single 2·`DATA_WIDTH` accumulator. It sits in the Multiplier directory as the default multiply unit behind the execution pipeline.

---
 rtl/booth_seq_multiplier.sv | 113 +++++++++++
 tb/tb_booth_seq_multiplier.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_seq_multiplier.sv
// Iterative radix-4 Booth multiplier: valid/ready on both sides, per-op signed/unsigned,
// DIGITS_PER_CYCLE digits per BUSY cycle. Optional early termination: BOOTH_SEQ_EARLY_TERM_EN.
module booth_seq_multiplier #(
  parameter int DATA_WIDTH       = 32,
  parameter int DIGITS_PER_CYCLE = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_signed,
  input  logic [DATA_WIDTH-1:0]     multiplicand,
  input  logic [DATA_WIDTH-1:0]     multiplier,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [2*DATA_WIDTH-1:0]   result
);

  localparam int NUM_DIGITS = (DATA_WIDTH + 3) / 2;
  localparam int NUM_CYCLES = (NUM_DIGITS + DIGITS_PER_CYCLE - 1) / DIGITS_PER_CYCLE;
  localparam int PW         = 2 * DATA_WIDTH;
  localparam int SH         = 2 * DIGITS_PER_CYCLE;
  // Headroom above the extended multiplier so every window of the last cycle stays in range.
  localparam int MW         = DATA_WIDTH + 3 + SH;
  localparam int CW         = $clog2(NUM_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic [PW-1:0]   mcand_q, mcand_d;
  logic [PW-1:0]   result_q, result_d;
  logic [MW-1:0]   mplr_q, mplr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   pp;
  logic [2:0]      win;
  logic            last;

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplr_d   = mplr_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    pp       = '0;
    win      = '0;
    last     = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = BUSY;
          mcand_d = {{(PW-DATA_WIDTH){in_signed & multiplicand[DATA_WIDTH-1]}}, multiplicand};
          mplr_d  = {{(MW-DATA_WIDTH-1){in_signed & multiplier[DATA_WIDTH-1]}}, multiplier, 1'b0};
          acc_d   = '0;
          cnt_d   = '0;
        end
      end
      BUSY: begin
        for (int j = 0; j < DIGITS_PER_CYCLE; j++) begin
          win = mplr_q[2*j +: 3];
          case (win)
            3'b001, 3'b010: pp = mcand_q;
            3'b011:         pp = mcand_q << 1;
            3'b100:         pp = -(mcand_q << 1);
            3'b101, 3'b110: pp = -mcand_q;
            default:        pp = '0;
          endcase
          acc_d = acc_d + (pp << (2*j));
        end
        // Sign fill keeps windows past the last real digit at 000/111, i.e. zero.
        mplr_d  = {{SH{mplr_q[MW-1]}}, mplr_q[MW-1:SH]};
        mcand_d = mcand_q << SH;
        cnt_d   = cnt_q + CW'(1);
        last    = (cnt_q == CW'(NUM_CYCLES - 1));
`ifdef BOOTH_SEQ_EARLY_TERM_EN
        last    = last | (&mplr_d) | ~(|mplr_d);
`endif
        if (last) begin
          state_d  = DONE;
          result_d = acc_d;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplr_q   <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplr_q   <= mplr_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;

endmodule

// File: tb/tb_booth_seq_multiplier.sv
// Self-checking bench for booth_seq_multiplier: five configurations (8/1, 8/5, 32/1, 32/3, 32/17)
// compared against an arithmetic reference product and latency model.
module tb_booth_seq_multiplier;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic iv [5];
  logic sg [5];
  logic ordy [5];
  logic rdy [5];
  logic ov [5];
  logic [31:0] av [5];
  logic [31:0] bv [5];
  logic [15:0] r0, r1;
  logic [63:0] r2, r3, r4;
  logic [63:0] res [5];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  booth_seq_multiplier #(.DATA_WIDTH(8), .DIGITS_PER_CYCLE(1)) u0 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(rdy[0]), .in_signed(sg[0]),
    .multiplicand(av[0][7:0]), .multiplier(bv[0][7:0]), .out_valid(ov[0]),
    .out_ready(ordy[0]), .result(r0));
  booth_seq_multiplier #(.DATA_WIDTH(8), .DIGITS_PER_CYCLE(5)) u1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(rdy[1]), .in_signed(sg[1]),
    .multiplicand(av[1][7:0]), .multiplier(bv[1][7:0]), .out_valid(ov[1]),
    .out_ready(ordy[1]), .result(r1));
  booth_seq_multiplier #(.DATA_WIDTH(32), .DIGITS_PER_CYCLE(1)) u2 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(rdy[2]), .in_signed(sg[2]),
    .multiplicand(av[2]), .multiplier(bv[2]), .out_valid(ov[2]),
    .out_ready(ordy[2]), .result(r2));
  booth_seq_multiplier #(.DATA_WIDTH(32), .DIGITS_PER_CYCLE(3)) u3 (
    .clk(clk), .rst(rst), .in_valid(iv[3]), .in_ready(rdy[3]), .in_signed(sg[3]),
    .multiplicand(av[3]), .multiplier(bv[3]), .out_valid(ov[3]),
    .out_ready(ordy[3]), .result(r3));
  booth_seq_multiplier #(.DATA_WIDTH(32), .DIGITS_PER_CYCLE(17)) u4 (
    .clk(clk), .rst(rst), .in_valid(iv[4]), .in_ready(rdy[4]), .in_signed(sg[4]),
    .multiplicand(av[4]), .multiplier(bv[4]), .out_valid(ov[4]),
    .out_ready(ordy[4]), .result(r4));

  assign res[0] = {48'h0, r0};
  assign res[1] = {48'h0, r1};
  assign res[2] = r2;
  assign res[3] = r3;
  assign res[4] = r4;

  function automatic int dw(int k);
    return (k < 2) ? 8 : 32;
  endfunction

  function automatic int dp(int k);
    case (k)
      0: return 1;
      1: return 5;
      2: return 1;
      3: return 3;
      default: return 17;
    endcase
  endfunction

  // Integer value of a w-bit operand under the chosen interpretation.
  function automatic longint opval(int w, bit sgn, logic [31:0] x);
    longint v;
    v = 0;
    for (int i = 0; i < w; i++) v[i] = x[i];
    if (sgn && x[w-1]) v = v - (longint'(1) << w);
    return v;
  endfunction

  function automatic logic [63:0] ref_prod(int k, bit sgn, logic [31:0] a, logic [31:0] b);
    logic [63:0] p;
    int w;
    w = dw(k);
    p = opval(w, sgn, a) * opval(w, sgn, b);
    if (w < 32) p = p & ((64'h1 << (2*w)) - 64'h1);
    return p;
  endfunction

  function automatic int exp_lat(int k, bit sgn, logic [31:0] b);
    int nd, nc;
    longint ext;
    nd  = (dw(k) + 3) / 2;
    nc  = (nd + dp(k) - 1) / dp(k);
    ext = opval(dw(k), sgn, b) * 2;
`ifdef BOOTH_SEQ_EARLY_TERM_EN
    for (int c = 1; c < nc; c++) begin
      if (((ext >>> (2*dp(k)*c)) == 0) || ((ext >>> (2*dp(k)*c)) == -1)) return c;
    end
`endif
    if (ext == 0) return nc;
    return nc;
  endfunction

  // One transaction; lat = edges from acceptance to out_valid, -1 on timeout.
  task automatic do_op(input int k, input bit sgn, input logic [31:0] a, input logic [31:0] b,
                       output logic [63:0] r, output int lat, output bit busy_ok, output bit post_rdy);
    int n;
    r = '0; lat = -1; busy_ok = 1'b1; post_rdy = 1'b0;
    @(negedge clk);
    n = 0;
    while (rdy[k] !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (rdy[k] !== 1'b1) return;
    iv[k] = 1'b1; sg[k] = sgn; av[k] = a; bv[k] = b;
    @(posedge clk); #1;
    iv[k] = 1'b0; av[k] = $urandom; bv[k] = $urandom; sg[k] = 1'($urandom);
    n = 0;
    while (n < 100) begin
      if (rdy[k] !== 1'b0) busy_ok = 1'b0;
      @(posedge clk); #1;
      n++;
      if (ov[k] === 1'b1) break;
    end
    if (ov[k] !== 1'b1) return;
    lat = n;
    r = res[k];
    @(negedge clk);
    ordy[k] = 1'b1;
    @(posedge clk); #1;
    ordy[k] = 1'b0;
    post_rdy = (rdy[k] === 1'b1) && (ov[k] === 1'b0);
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (rdy[k] !== 1'b1 || ov[k] !== 1'b0 || res[k] !== 64'h0) begin
        errors++;
        $display("FAIL reset_state[%0d]: in_ready=%b out_valid=%b result=%h, required 1 0 0",
                 k, rdy[k], ov[k], res[k]);
      end
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset_mid_busy;
    logic [63:0] r;
    int lat;
    bit bok, prdy;
    @(negedge clk);
    iv[0] = 1'b1; sg[0] = 1'b0; av[0] = 32'hAB; bv[0] = 32'hCD;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checks++;
    if (ov[0] !== 1'b0 || rdy[0] !== 1'b1 || res[0] !== 64'h0) begin
      errors++;
      $display("FAIL reset_mid_busy: out_valid=%b in_ready=%b result=%h, required 0 1 0",
               ov[0], rdy[0], res[0]);
    end
    @(negedge clk);
    rst = 1'b0;
    do_op(0, 1'b0, 32'd7, 32'd9, r, lat, bok, prdy);
    checks++;
    if (r !== 64'h3F) begin
      errors++;
      $display("FAIL after_reset_7x9: result=%h, required 003f", r);
    end
    checks++;
    if (lat !== exp_lat(0, 1'b0, 32'd9)) begin
      errors++;
      $display("FAIL after_reset_latency: got %0d, required %0d", lat, exp_lat(0, 1'b0, 32'd9));
    end
  endtask

  task automatic test_signed_extreme;
    logic [63:0] r;
    int lat;
    bit bok, prdy;
    logic [31:0] ta [3] = '{32'h80, 32'hFF, 32'h80};
    logic [31:0] tb [3] = '{32'h80, 32'h01, 32'h80};
    int          tk [3] = '{0, 0, 1};
    logic [63:0] te [3] = '{64'h4000, 64'hFFFF, 64'h4000};
    for (int i = 0; i < 3; i++) begin
      do_op(tk[i], 1'b1, ta[i], tb[i], r, lat, bok, prdy);
      checks++;
      if (r !== te[i]) begin
        errors++;
        $display("FAIL signed_extreme[%0d]: result=%h, required %h", i, r, te[i]);
      end
      checks++;
      if (lat !== exp_lat(tk[i], 1'b1, tb[i])) begin
        errors++;
        $display("FAIL signed_extreme_latency[%0d]: got %0d, required %0d", i, lat,
                 exp_lat(tk[i], 1'b1, tb[i]));
      end
    end
  endtask

  task automatic test_unsigned_extreme;
    logic [63:0] r;
    int lat;
    bit bok, prdy;
    do_op(0, 1'b0, 32'hFF, 32'hFF, r, lat, bok, prdy);
    checks++;
    if (r !== 64'hFE01) begin
      errors++;
      $display("FAIL unsigned_255x255: result=%h, required fe01", r);
    end
    do_op(0, 1'b0, 32'd0, 32'd200, r, lat, bok, prdy);
    checks++;
    if (r !== 64'h0) begin
      errors++;
      $display("FAIL unsigned_0x200: result=%h, required 0000", r);
    end
    do_op(2, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, r, lat, bok, prdy);
    checks++;
    if (r !== 64'hFFFFFFFE00000001) begin
      errors++;
      $display("FAIL unsigned_32_full: result=%h, required fffffffe00000001", r);
    end
  endtask

  task automatic test_multi_digit;
    logic [63:0] r;
    int lat;
    bit bok, prdy;
    for (int k = 2; k < 5; k++) begin
      do_op(k, 1'b1, 32'h80000000, 32'h7FFFFFFF, r, lat, bok, prdy);
      checks++;
      if (r !== 64'hC000000080000000) begin
        errors++;
        $display("FAIL multi_digit[%0d]: result=%h, required c000000080000000", k, r);
      end
      checks++;
      if (lat !== exp_lat(k, 1'b1, 32'h7FFFFFFF)) begin
        errors++;
        $display("FAIL multi_digit_latency[%0d]: got %0d, required %0d", k, lat,
                 exp_lat(k, 1'b1, 32'h7FFFFFFF));
      end
    end
  endtask

  task automatic test_early_term;
    logic [63:0] r;
    int lat;
    bit bok, prdy;
    do_op(2, 1'b1, 32'd5, 32'd3, r, lat, bok, prdy);
    checks++;
    if (r !== 64'd15 || lat !== exp_lat(2, 1'b1, 32'd3)) begin
      errors++;
      $display("FAIL early_5x3: result=%h lat=%0d, required %h lat=%0d", r, lat, 64'd15,
               exp_lat(2, 1'b1, 32'd3));
    end
    do_op(2, 1'b1, 32'd5, 32'hFFFFFFFF, r, lat, bok, prdy);
    checks++;
    if (r !== 64'hFFFFFFFFFFFFFFFB || lat !== exp_lat(2, 1'b1, 32'hFFFFFFFF)) begin
      errors++;
      $display("FAIL early_5xm1: result=%h lat=%0d, required fffffffffffffffb lat=%0d", r, lat,
               exp_lat(2, 1'b1, 32'hFFFFFFFF));
    end
  endtask

  task automatic test_backpressure;
    logic [63:0] held, want;
    int n;
    @(negedge clk);
    iv[0] = 1'b1; sg[0] = 1'b0; av[0] = 32'h12; bv[0] = 32'h34;
    @(posedge clk); #1;
    av[0] = 32'h56; bv[0] = 32'h78;
    n = 0;
    while (ov[0] !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    want = ref_prod(0, 1'b0, 32'h12, 32'h34);
    checks++;
    if (ov[0] !== 1'b1 || res[0] !== want) begin
      errors++;
      $display("FAIL backpressure_first: out_valid=%b result=%h, required 1 %h", ov[0], res[0], want);
    end
    held = res[0];
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      checks++;
      if (res[0] !== held || rdy[0] !== 1'b0 || ov[0] !== 1'b1) begin
        errors++;
        $display("FAIL backpressure_hold[%0d]: result=%h in_ready=%b out_valid=%b, required %h 0 1",
                 c, res[0], rdy[0], ov[0], held);
      end
    end
    @(negedge clk);
    ordy[0] = 1'b1; av[0] = 32'h9A; bv[0] = 32'hBC;
    @(posedge clk); #1;
    ordy[0] = 1'b0;
    checks++;
    if (rdy[0] !== 1'b1) begin
      errors++;
      $display("FAIL backpressure_release: in_ready=%b, required 1", rdy[0]);
    end
    @(posedge clk); #1;
    iv[0] = 1'b0;
    checks++;
    if (rdy[0] !== 1'b0) begin
      errors++;
      $display("FAIL backpressure_accept: in_ready=%b, required 0", rdy[0]);
    end
    n = 0;
    while (ov[0] !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    want = ref_prod(0, 1'b0, 32'h9A, 32'hBC);
    checks++;
    if (res[0] !== want || n !== exp_lat(0, 1'b0, 32'hBC)) begin
      errors++;
      $display("FAIL backpressure_second: result=%h lat=%0d, required %h lat=%0d", res[0], n, want,
               exp_lat(0, 1'b0, 32'hBC));
    end
    @(negedge clk);
    ordy[0] = 1'b1;
    @(posedge clk); #1;
    ordy[0] = 1'b0;
  endtask

  task automatic test_random;
    logic [63:0] r, want;
    logic [31:0] a, b;
    int lat;
    bit sgn, bok, prdy;
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < 16; i++) begin
        a = $urandom; b = $urandom; sgn = 1'($urandom);
        case ($urandom_range(0, 5))
          0: b = 32'h0;
          1: b = 32'hFFFFFFFF;
          2: b = b & 32'hF;
          default: ;
        endcase
        want = ref_prod(k, sgn, a, b);
        do_op(k, sgn, a, b, r, lat, bok, prdy);
        checks++;
        if (r !== want || lat !== exp_lat(k, sgn, b) || !bok || !prdy) begin
          errors++;
          $display("FAIL random[%0d.%0d]: a=%h b=%h s=%b result=%h lat=%0d busy_ok=%b idle_ok=%b, required %h lat=%0d",
                   k, i, a, b, sgn, r, lat, bok, prdy, want, exp_lat(k, sgn, b));
        end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < 5; k++) begin
      iv[k] = 1'b0; sg[k] = 1'b0; ordy[k] = 1'b0; av[k] = '0; bv[k] = '0;
    end
    test_reset;
    test_reset_mid_busy;
    test_signed_extreme;
    test_unsigned_extreme;
    test_multi_digit;
    test_early_term;
    test_backpressure;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
